// File: rtl/kernel_sram_ctrl_if.sv
// Shared kernel-SRAM port bundle: the controller drives it (master), the 32 coefficient
// banks consume it (slave).
interface kernel_sram_ctrl_if #(
   parameter int WIDTH     = 16,
   parameter int HEIGHT    = 128,
   parameter int NUM_BANKS = 32
);
   localparam int AW = $clog2(HEIGHT);

   logic [AW-1:0]        KERNEL_read_addr;
   logic [AW-1:0]        KERNEL_write_addr;
   logic                 KERNEL_re;
   logic [NUM_BANKS-1:0] KERNEL_we;
   logic [WIDTH-1:0]     KERNEL_din;

   modport master (
      output KERNEL_read_addr, KERNEL_write_addr, KERNEL_re, KERNEL_we, KERNEL_din
   );

   modport slave (
      input KERNEL_read_addr, KERNEL_write_addr, KERNEL_re, KERNEL_we, KERNEL_din
   );
endinterface

// File: rtl/kernel_sram_ctrl.sv
// Kernel coefficient SRAM controller: streams kernels into 32 banks and fetches a slot back.
// Define KERNEL_CTRL_BOUNDS_CHECK_EN to reject slots beyond HEIGHT/NUM_COEF with an err pulse.
//
// state | meaning
// IDLE  | waiting for load_start / fetch_start
// LOAD  | s_ready high, each beat written to bank n/9, word base + n%9
// FETCH | reading words base+0 .. base+8 from all banks in parallel
module kernel_sram_ctrl #(
   parameter int WIDTH     = 16,
   parameter int HEIGHT    = 128,
   parameter int NUM_COEF  = 9,
   parameter int NUM_BANKS = 32
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  load_start,
   input  logic [3:0]            load_slot,
   input  logic                  fetch_start,
   input  logic [3:0]            fetch_slot,
   input  logic [WIDTH-1:0]      s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  busy,
   output logic                  load_done,
   output logic                  fetch_done,
   output logic                  err,
   output logic                  coef_valid,
   output logic [3:0]            coef_idx,
   kernel_sram_ctrl_if.master    sram
);
   localparam int AW        = $clog2(HEIGHT);
   localparam int BW        = $clog2(NUM_BANKS);
   localparam int NUM_BEATS = NUM_BANKS * NUM_COEF;
   localparam int CW        = $clog2(NUM_BEATS);
   localparam logic [3:0] LAST_K = 4'(NUM_COEF - 1);

   typedef enum logic [1:0] {IDLE, LOAD, FETCH} state_t;

   state_t               state_q, state_d;
   logic [3:0]           slot_q, slot_d;
   logic [3:0]           k_q, k_d;
   logic [BW-1:0]        bank_q, bank_d;
   logic [CW-1:0]        beats_left_q, beats_left_d;
   logic [AW-1:0]        rd_addr_q, rd_addr_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic                 re_q, re_d;
   logic [NUM_BANKS-1:0] we_q, we_d;
   logic [WIDTH-1:0]     din_q, din_d;
   logic                 coef_valid_q, coef_valid_d;
   logic [3:0]           coef_idx_q, coef_idx_d;
   logic                 load_done_q, load_done_d;
   logic                 fetch_done_q, fetch_done_d;
   logic                 load_ok, fetch_ok;

   // Address arithmetic wraps modulo HEIGHT so oversized slots alias rather than overflow.
   function automatic logic [AW-1:0] slot_addr(input logic [3:0] slot, input logic [3:0] k);
      int full;
      full = int'(slot) * NUM_COEF + int'(k);
      return AW'(full % HEIGHT);
   endfunction

`ifdef KERNEL_CTRL_BOUNDS_CHECK_EN
   localparam int NUM_SLOTS = HEIGHT / NUM_COEF;
   logic err_q, err_d;

   assign load_ok  = int'(load_slot) < NUM_SLOTS;
   assign fetch_ok = int'(fetch_slot) < NUM_SLOTS;
   assign err_d    = !busy && (load_start ? !load_ok : (fetch_start && !fetch_ok));

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) err_q <= 1'b0;
      else            err_q <= err_d;
   end

   assign err = err_q;
`else
   assign load_ok  = 1'b1;
   assign fetch_ok = 1'b1;
   assign err      = 1'b0;
`endif

   // A done/coef_valid cycle still counts as busy, so starts are gated there as well.
   assign busy    = (state_q != IDLE) | load_done_q | fetch_done_q | coef_valid_q;
   assign s_ready = (state_q == LOAD);

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      k_d          = k_q;
      bank_d       = bank_q;
      beats_left_d = beats_left_q;
      rd_addr_d    = rd_addr_q;
      wr_addr_d    = wr_addr_q;
      din_d        = din_q;
      re_d         = 1'b0;
      we_d         = '0;
      load_done_d  = 1'b0;
      fetch_done_d = re_q && (k_q == LAST_K);
      coef_valid_d = re_q;
      coef_idx_d   = re_q ? k_q : coef_idx_q;

      unique case (state_q)
         IDLE: begin
            if (!busy && load_start) begin
               if (load_ok) begin
                  state_d      = LOAD;
                  slot_d       = load_slot;
                  k_d          = '0;
                  bank_d       = '0;
                  beats_left_d = CW'(NUM_BEATS - 1);
               end
            end else if (!busy && fetch_start) begin
               if (fetch_ok) begin
                  state_d   = FETCH;
                  slot_d    = fetch_slot;
                  k_d       = '0;
                  re_d      = 1'b1;
                  rd_addr_d = slot_addr(fetch_slot, 4'd0);
               end
            end
         end

         LOAD: begin
            if (s_valid) begin
               we_d[bank_q] = 1'b1;
               wr_addr_d    = slot_addr(slot_q, k_q);
               din_d        = s_data;
               if (beats_left_q == '0) begin
                  state_d     = IDLE;
                  load_done_d = 1'b1;
               end else begin
                  beats_left_d = beats_left_q - CW'(1);
                  if (k_q == LAST_K) begin
                     k_d    = '0;
                     bank_d = bank_q + BW'(1);
                  end else begin
                     k_d = k_q + 4'd1;
                  end
               end
            end
         end

         FETCH: begin
            if (k_q == LAST_K) begin
               state_d = IDLE;
            end else begin
               k_d       = k_q + 4'd1;
               re_d      = 1'b1;
               rd_addr_d = slot_addr(slot_q, k_q + 4'd1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         k_q          <= '0;
         bank_q       <= '0;
         beats_left_q <= '0;
         rd_addr_q    <= '0;
         wr_addr_q    <= '0;
         re_q         <= 1'b0;
         we_q         <= '0;
         din_q        <= '0;
         coef_valid_q <= 1'b0;
         coef_idx_q   <= '0;
         load_done_q  <= 1'b0;
         fetch_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         k_q          <= k_d;
         bank_q       <= bank_d;
         beats_left_q <= beats_left_d;
         rd_addr_q    <= rd_addr_d;
         wr_addr_q    <= wr_addr_d;
         re_q         <= re_d;
         we_q         <= we_d;
         din_q        <= din_d;
         coef_valid_q <= coef_valid_d;
         coef_idx_q   <= coef_idx_d;
         load_done_q  <= load_done_d;
         fetch_done_q <= fetch_done_d;
      end
   end

   assign load_done              = load_done_q;
   assign fetch_done             = fetch_done_q;
   assign coef_valid             = coef_valid_q;
   assign coef_idx               = coef_idx_q;
   assign sram.KERNEL_read_addr  = rd_addr_q;
   assign sram.KERNEL_write_addr = wr_addr_q;
   assign sram.KERNEL_re         = re_q;
   assign sram.KERNEL_we         = we_q;
   assign sram.KERNEL_din        = din_q;
endmodule

// File: tb/tb_kernel_sram_ctrl.sv
// Bench for kernel_sram_ctrl: table of load/fetch vectors, hand-written reset-abort and
// busy-gating sequences, then random operations checked against an arithmetic model.
module tb_kernel_sram_ctrl;
   localparam int WIDTH     = 16;
   localparam int HEIGHT    = 128;
   localparam int NUM_COEF  = 9;
   localparam int NUM_BANKS = 32;
   localparam int BEATS     = NUM_BANKS * NUM_COEF;
   localparam logic [NUM_BANKS-1:0] ONE_B = 1;

   logic             clk = 1'b0;
   logic             arst_n_in = 1'b1;
   logic             load_start = 1'b0;
   logic [3:0]       load_slot = '0;
   logic             fetch_start = 1'b0;
   logic [3:0]       fetch_slot = '0;
   logic [WIDTH-1:0] s_data = '0;
   logic             s_valid = 1'b0;
   logic             s_ready, busy, load_done, fetch_done, err, coef_valid;
   logic [3:0]       coef_idx;

   kernel_sram_ctrl_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_BANKS(NUM_BANKS)) sram_if ();

   kernel_sram_ctrl #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_COEF(NUM_COEF), .NUM_BANKS(NUM_BANKS)
   ) dut (
      .clk(clk), .arst_n_in(arst_n_in),
      .load_start(load_start), .load_slot(load_slot),
      .fetch_start(fetch_start), .fetch_slot(fetch_slot),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .busy(busy), .load_done(load_done), .fetch_done(fetch_done), .err(err),
      .coef_valid(coef_valid), .coef_idx(coef_idx),
      .sram(sram_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   typedef struct {int cyc; logic [NUM_BANKS-1:0] we; int addr; int data;} wr_t;
   typedef struct {int cyc; int val;} ev_t;
   typedef struct {bit is_load; int slot; int mode; bit flag; int exp_count; int exp_first; int exp_last;} vec_t;

   wr_t wr_q[$];
   ev_t rd_q[$], cv_q[$], beat_q[$];
   int  ld_q[$], fd_q[$], err_q[$];
   int  busy_cnt, ready_cnt;

   always @(negedge clk) begin
      if (arst_n_in) begin
         if (sram_if.KERNEL_we != '0)
            wr_q.push_back('{cyc, sram_if.KERNEL_we, int'(sram_if.KERNEL_write_addr), int'(sram_if.KERNEL_din)});
         if (sram_if.KERNEL_re) rd_q.push_back('{cyc, int'(sram_if.KERNEL_read_addr)});
         if (coef_valid) cv_q.push_back('{cyc, int'(coef_idx)});
         if (s_valid && s_ready) beat_q.push_back('{cyc, int'(s_data)});
         if (load_done) ld_q.push_back(cyc);
         if (fetch_done) fd_q.push_back(cyc);
         if (err) err_q.push_back(cyc);
         if (busy) busy_cnt++;
         if (s_ready) ready_cnt++;
      end
   end

   task automatic clear_mon();
      wr_q.delete(); rd_q.delete(); cv_q.delete(); beat_q.delete();
      ld_q.delete(); fd_q.delete(); err_q.delete();
      busy_cnt = 0; ready_cnt = 0;
   endtask

   function automatic int exp_addr(int slot, int k);
      return (slot * NUM_COEF + k) % HEIGHT;
   endfunction

   function automatic bit slot_ok(int slot);
`ifdef KERNEL_CTRL_BOUNDS_CHECK_EN
      return slot < HEIGHT / NUM_COEF;
`else
      return slot < 16;
`endif
   endfunction

   function automatic bit any_out();
      return |{s_ready, busy, load_done, fetch_done, err, coef_valid, coef_idx,
               sram_if.KERNEL_re, sram_if.KERNEL_we, sram_if.KERNEL_read_addr,
               sram_if.KERNEL_write_addr, sram_if.KERNEL_din};
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      compared++;
      if (got != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic do_load(input int slot, input int mode, input bit both, input bit rnd,
                          output int first_a, output int last_a, output int count);
      int data[BEATS];
      int t, sent, budget, bad;
      bit hs, ok;
      for (int n = 0; n < BEATS; n++) data[n] = rnd ? int'($urandom_range(65535)) : n;
      ok = slot_ok(slot);
      clear_mon();
      @(posedge clk); #1;
      load_start = 1'b1; load_slot = 4'(slot);
      fetch_start = both; fetch_slot = 4'($urandom_range(15));
      t = cyc;
      @(posedge clk); #1;
      load_start = 1'b0;
      sent = 0; budget = 0;
      if (ok) begin
         while (sent < BEATS && budget < 3 * BEATS) begin
            case (mode)
               0:       s_valid = 1'b1;
               1:       s_valid = (budget % 2 == 0);
               default: s_valid = ($urandom_range(2) != 0);
            endcase
            s_data = s_valid ? 16'(data[sent]) : 16'($urandom_range(65535));
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) sent++;
            budget++;
         end
         check("load_beats_sent", sent, BEATS);
      end
      s_valid = 1'b0; fetch_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      check("load_wr_count", wr_q.size(), ok ? BEATS : 0);
      check("load_beat_count", beat_q.size(), ok ? BEATS : 0);
      bad = -1;
      for (int n = 0; n < wr_q.size() && n < beat_q.size(); n++) begin
         if (bad < 0 && (wr_q[n].cyc != beat_q[n].cyc + 1 || wr_q[n].we != (ONE_B << (n / NUM_COEF)) ||
                         wr_q[n].addr != exp_addr(slot, n % NUM_COEF) || wr_q[n].data != data[n]))
            bad = n;
      end
      compared++;
      if (bad >= 0) begin
         mismatched++;
         $display("FAIL load_wr_seq: write %0d got cyc=%0d we=%h addr=%0d din=%0d, expected cyc=%0d we=%h addr=%0d din=%0d",
                  bad, wr_q[bad].cyc, wr_q[bad].we, wr_q[bad].addr, wr_q[bad].data,
                  beat_q[bad].cyc + 1, ONE_B << (bad / NUM_COEF), exp_addr(slot, bad % NUM_COEF), data[bad]);
      end
      if (beat_q.size() > 0) begin
         check("load_done_at", ld_q.size() == 1 ? ld_q[0] : -1, beat_q[$].cyc + 1);
         check("load_ready_cycles", ready_cnt, beat_q[$].cyc - t);
         if (mode < 2) check("load_last_beat_cyc", beat_q[$].cyc, t + 1 + (mode + 1) * (BEATS - 1));
      end else begin
         check("load_done_count", ld_q.size(), 0);
      end
      check("load_no_read", rd_q.size(), 0);
      check("load_err_count", err_q.size(), ok ? 0 : 1);
      first_a = wr_q.size() > 0 ? wr_q[0].addr : -1;
      last_a  = wr_q.size() > 0 ? wr_q[$].addr : -1;
      count   = wr_q.size();
   endtask

   task automatic do_fetch(input int slot, input bit hold,
                           output int first_a, output int last_a, output int count);
      int t, bad, n_exp;
      bit ok;
      ok = slot_ok(slot);
      clear_mon();
      @(posedge clk); #1;
      fetch_start = 1'b1; fetch_slot = 4'(slot); load_start = 1'b0;
      s_valid = 1'b1; s_data = 16'($urandom_range(65535));
      t = cyc;
      repeat (hold ? 11 : 1) @(posedge clk);
      #1;
      fetch_start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      s_valid = 1'b0;

      n_exp = ok ? NUM_COEF : 0;
      check("fetch_re_count", rd_q.size(), n_exp);
      check("fetch_cv_count", cv_q.size(), n_exp);
      bad = -1;
      for (int k = 0; k < rd_q.size() && k < cv_q.size(); k++) begin
         if (bad < 0 && (rd_q[k].cyc != t + 1 + k || rd_q[k].val != exp_addr(slot, k) ||
                         cv_q[k].cyc != t + 2 + k || cv_q[k].val != k))
            bad = k;
      end
      compared++;
      if (bad >= 0) begin
         mismatched++;
         $display("FAIL fetch_seq: read %0d got re_cyc=%0d addr=%0d cv_cyc=%0d idx=%0d, expected re_cyc=%0d addr=%0d cv_cyc=%0d idx=%0d",
                  bad, rd_q[bad].cyc, rd_q[bad].val, cv_q[bad].cyc, cv_q[bad].val,
                  t + 1 + bad, exp_addr(slot, bad), t + 2 + bad, bad);
      end
      check("fetch_done_at", fd_q.size() == 1 ? fd_q[0] : -1, ok ? t + NUM_COEF + 1 : -1);
      check("fetch_busy_cycles", busy_cnt, ok ? NUM_COEF + 1 : 0);
      check("fetch_err_count", err_q.size(), ok ? 0 : 1);
      check("fetch_no_write", wr_q.size(), 0);
      if (ok) check("fetch_addr_hold", sram_if.KERNEL_read_addr, exp_addr(slot, NUM_COEF - 1));
      first_a = rd_q.size() > 0 ? rd_q[0].val : -1;
      last_a  = rd_q.size() > 0 ? rd_q[$].val : -1;
      count   = rd_q.size();
   endtask

   initial begin
      vec_t vecs[8];
      int fa, la, cnt, sent, budget, slot;
      bit hs;

      vecs[0] = '{1'b1, 2, 0, 1'b0, BEATS, 18, 26};
      vecs[1] = '{1'b0, 2, 0, 1'b1, 9, 18, 26};
      vecs[2] = '{1'b1, 2, 1, 1'b0, BEATS, 18, 26};
      vecs[3] = '{1'b1, 5, 0, 1'b1, BEATS, 45, 53};
`ifdef KERNEL_CTRL_BOUNDS_CHECK_EN
      vecs[4] = '{1'b0, 14, 0, 1'b0, 0, -1, -1};
      vecs[5] = '{1'b0, 15, 0, 1'b0, 0, -1, -1};
      vecs[7] = '{1'b1, 15, 2, 1'b0, 0, -1, -1};
`else
      vecs[4] = '{1'b0, 14, 0, 1'b0, 9, 126, 6};
      vecs[5] = '{1'b0, 15, 0, 1'b0, 9, 7, 15};
      vecs[7] = '{1'b1, 15, 2, 1'b0, BEATS, 7, 15};
`endif
      vecs[6] = '{1'b0, 0, 0, 1'b0, 9, 0, 8};

      #2 arst_n_in = 1'b0;
      #1 check("reset_outputs_zero", any_out(), 0);
      repeat (3) @(posedge clk);
      #1 arst_n_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_s_ready", s_ready, 0);
      check("idle_busy", busy, 0);

      foreach (vecs[i]) begin
         if (vecs[i].is_load) do_load(vecs[i].slot, vecs[i].mode, vecs[i].flag, 1'b0, fa, la, cnt);
         else                 do_fetch(vecs[i].slot, vecs[i].flag, fa, la, cnt);
         check($sformatf("vec%0d_count", i), cnt, vecs[i].exp_count);
         check($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_first);
         check($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
      end

      // Reset in the middle of a load: outputs drop at once, no done, next load starts clean.
      clear_mon();
      @(posedge clk); #1;
      load_start = 1'b1; load_slot = 4'd3;
      @(posedge clk); #1;
      load_start = 1'b0;
      sent = 0; budget = 0;
      while (sent < 101 && budget < 400) begin
         s_valid = 1'b1; s_data = 16'(sent);
         @(negedge clk);
         hs = s_valid && s_ready;
         @(posedge clk); #1;
         if (hs) sent++;
         budget++;
      end
      check("abort_beats", sent, 101);
      check("abort_we_active", sram_if.KERNEL_we, ONE_B << (100 / NUM_COEF));
      #2 arst_n_in = 1'b0;
      #1 check("abort_outputs_zero", any_out(), 0);
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 arst_n_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", ld_q.size(), 0);
      check("abort_idle", busy, 0);
      do_load(0, 0, 1'b0, 1'b0, fa, la, cnt);
      check("fresh_first_addr", fa, 0);
      check("fresh_first_we", wr_q.size() > 0 ? longint'(wr_q[0].we) : -1, 1);

      repeat (6) begin
         slot = int'($urandom_range(15));
         if ($urandom_range(1) == 1) do_load(slot, 2, 1'($urandom_range(1)), 1'b1, fa, la, cnt);
         else                        do_fetch(slot, 1'($urandom_range(1)), fa, la, cnt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
